// File: rtl/sync_fifo_thresh_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_thresh.
// The master drives requests and threshold levels; the slave (the FIFO) drives data and flags.
interface sync_fifo_thresh_if #(
    parameter int unsigned pDATA_WIDTH = 8
);
    logic                   wen;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   full;
    logic                   almost_full;
    logic                   overflow;
    logic [31:0]            full_threshold_value;
    logic                   full_threshold;
    logic                   ren;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   empty;
    logic                   almost_empty;
    logic [31:0]            empty_threshold_value;
    logic                   empty_threshold;
    logic                   underflow;

    modport master (
        output wen, wdata, full_threshold_value, ren, empty_threshold_value,
        input  full, almost_full, overflow, full_threshold, rdata, empty, almost_empty,
               empty_threshold, underflow
    );

    modport slave (
        input  wen, wdata, full_threshold_value, ren, empty_threshold_value,
        output full, almost_full, overflow, full_threshold, rdata, empty, almost_empty,
               empty_threshold, underflow
    );
endinterface

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with register-array storage, registered overflow/underflow pulses,
// programmable fill-level threshold flags and optional first-word-fall-through reads.
module sync_fifo_thresh #(
    parameter int unsigned pDATA_WIDTH  = 8,
    parameter int unsigned pDEPTH       = 32,
    parameter bit          pFALLTHROUGH = 1'b0
) (
    input logic               clk,
    input logic               srst_n,
    sync_fifo_thresh_if.slave fifo_io
);
    localparam int unsigned AW = $clog2(pDEPTH);
    localparam logic [AW+1:0] AlmostFullLvl  = (AW+2)'(pDEPTH - 1);
    localparam logic [AW+1:0] AlmostEmptyLvl = (AW+2)'(1);

    logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];
    logic [AW:0]            wptr_q, wptr_d;
    logic [AW:0]            rptr_q, rptr_d;
    logic                   overflow_q, underflow_q;
    logic                   empty, full;
    logic                   wr_accept, rd_accept;
    logic [AW:0]            count;
    logic [AW+1:0]          count_ext, thr_full, thr_empty;
    logic                   unused_thresh_bits;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign wr_accept = fifo_io.wen && !full;
    assign rd_accept = fifo_io.ren && !empty;

    assign wptr_d = wptr_q + (AW+1)'(wr_accept);
    assign rptr_d = rptr_q + (AW+1)'(rd_accept);

    // Widened so a threshold compare can never alias across pointer wrap.
    assign count     = wptr_q - rptr_q;
    assign count_ext = {1'b0, count};
    assign thr_full  = {2'b00, fifo_io.full_threshold_value[AW-1:0]};
    assign thr_empty = {2'b00, fifo_io.empty_threshold_value[AW-1:0]};

    assign unused_thresh_bits = ^{fifo_io.full_threshold_value[31:AW],
                                  fifo_io.empty_threshold_value[31:AW]};

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= fifo_io.wen && full;
            underflow_q <= fifo_io.ren && empty;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wptr_q[AW-1:0]] <= fifo_io.wdata;
        end
    end

    if (pFALLTHROUGH) begin : g_fwft
        assign fifo_io.rdata = mem_q[rptr_q[AW-1:0]];
    end else begin : g_reg
        logic [pDATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge clk or negedge srst_n) begin
            if (!srst_n) begin
                rdata_q <= '0;
            end else if (rd_accept) begin
                rdata_q <= mem_q[rptr_q[AW-1:0]];
            end
        end

        assign fifo_io.rdata = rdata_q;
    end

    assign fifo_io.empty           = empty;
    assign fifo_io.full            = full;
    assign fifo_io.almost_full     = (count_ext >= AlmostFullLvl);
    assign fifo_io.almost_empty    = (count_ext <= AlmostEmptyLvl);
    assign fifo_io.full_threshold  = (count_ext >= thr_full);
    assign fifo_io.empty_threshold = (count_ext <= thr_empty);
    assign fifo_io.overflow        = overflow_q;
    assign fifo_io.underflow       = underflow_q;
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Drives a registered-read and a fall-through FIFO with identical traffic and checks both
// against a queue-based occupancy model.
module tb_sync_fifo_thresh;
    localparam int Depth = 32;

    logic clk = 1'b0;
    logic srst_n = 1'b0;

    sync_fifo_thresh_if #(.pDATA_WIDTH(8)) reg_if ();
    sync_fifo_thresh_if #(.pDATA_WIDTH(8)) fwft_if ();

    sync_fifo_thresh #(.pDATA_WIDTH(8), .pDEPTH(Depth), .pFALLTHROUGH(1'b0)) dut_reg (
        .clk     (clk),
        .srst_n  (srst_n),
        .fifo_io (reg_if)
    );

    sync_fifo_thresh #(.pDATA_WIDTH(8), .pDEPTH(Depth), .pFALLTHROUGH(1'b1)) dut_fwft (
        .clk     (clk),
        .srst_n  (srst_n),
        .fifo_io (fwft_if)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic       exp_ovf, exp_udf;
    logic [7:0] exp_rd;
    int         tf, te;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        reg_if.wen = w;   reg_if.ren = r;   reg_if.wdata = d;
        fwft_if.wen = w;  fwft_if.ren = r;  fwft_if.wdata = d;
        reg_if.full_threshold_value = tf;   reg_if.empty_threshold_value = te;
        fwft_if.full_threshold_value = tf;  fwft_if.empty_threshold_value = te;
    endtask

    task automatic check_flags(input string p, input logic e, input logic ae, input logic f,
                               input logic af, input logic ovf, input logic udf,
                               input logic ft, input logic et);
        int n = q.size();
        check({p, ".empty"}, e, n == 0);
        check({p, ".almost_empty"}, ae, n <= 1);
        check({p, ".full"}, f, n == Depth);
        check({p, ".almost_full"}, af, n >= Depth - 1);
        check({p, ".overflow"}, ovf, exp_ovf);
        check({p, ".underflow"}, udf, exp_udf);
        check({p, ".full_threshold"}, ft, n >= tf);
        check({p, ".empty_threshold"}, et, n <= te);
    endtask

    task automatic check_all();
        check_flags("reg", reg_if.empty, reg_if.almost_empty, reg_if.full, reg_if.almost_full,
                    reg_if.overflow, reg_if.underflow, reg_if.full_threshold,
                    reg_if.empty_threshold);
        check_flags("fwft", fwft_if.empty, fwft_if.almost_empty, fwft_if.full,
                    fwft_if.almost_full, fwft_if.overflow, fwft_if.underflow,
                    fwft_if.full_threshold, fwft_if.empty_threshold);
        check("reg.rdata", reg_if.rdata, exp_rd);
        if (q.size() != 0) check("fwft.rdata", fwft_if.rdata, q[0]);
    endtask

    // One clock of traffic: model follows the accept rules, then outputs are checked.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic rd_ok, wr_ok;
        drive(w, r, d);
        @(posedge clk);
        exp_ovf = w && (q.size() == Depth);
        exp_udf = r && (q.size() == 0);
        rd_ok = r && (q.size() != 0);
        wr_ok = w && (q.size() != Depth);
        if (rd_ok) exp_rd = q.pop_front();
        if (wr_ok) q.push_back(d);
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        exp_rd  = 8'h00;
    endtask

    initial begin
        tf = 20;
        te = 5;
        drive(1'b0, 1'b0, 8'h00);
        model_reset();
        repeat (3) @(negedge clk);
        srst_n = 1'b1;
        check_all();

        // Fill 0..31 plus one dropped write, then drain plus one extra read.
        for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hEE);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Fall-through head visible without a read, then popped.
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Simultaneous requests at the full and empty boundaries.
        for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'h5A);
        check("count_after_full_wr", q.size(), Depth - 1);
        for (int i = 0; i < Depth - 1; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        check("count_after_empty_wr", q.size(), 1);
        step(1'b0, 1'b1, 8'h00);

        // Steady occupancy of 3 across many pointer wraps.
        tf = 3;
        te = 2;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

        // Random traffic, biased first toward filling then toward draining.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                tf = $urandom_range(0, Depth - 1);
                te = $urandom_range(0, Depth - 1);
            end
            if (i < 200)
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 8'($urandom));
            else
                step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, 8'($urandom));
        end

        // Asynchronous reset in the middle of a cycle with 10 words stored.
        tf = 0;
        te = 0;
        while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(i + 100));
        drive(1'b0, 1'b0, 8'h00);
        #2;
        srst_n = 1'b0;
        #1;
        check("rst.reg.empty", reg_if.empty, 1'b1);
        check("rst.fwft.empty", fwft_if.empty, 1'b1);
        check("rst.reg.rdata", reg_if.rdata, 8'h00);
        model_reset();
        @(negedge clk);
        srst_n = 1'b1;
        check_all();
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
